port_uart: RTL

Byte-wide UART peripheral that responds on the 8-bit port bus driven by the CPU subsystem (`port_id` / `write_strobe` / `out_port` / `read_strobe` / `in_port`). It decodes a 4-port window, buffers transmit and receive bytes in FIFOs, and serializes/deserializes 8N1 frames at a programmable bit rate. Its `in_port` output is zero when the window is not addressed, so several responders can be OR-combined onto the CPU's `in_port`.

---
 rtl/port_uart.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/port_uart.sv
// port_uart: port-bus mapped 8N1 UART with TX/RX FIFOs and a programmable bit divisor.
module port_uart #(
  parameter logic [7:0]  BASE_PORT   = 8'h00,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  input  logic       uart_rx,
  output logic       uart_tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 16;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  // bus qualification
  logic          wr_q, rd_q;
  logic          wr_acc, rd_acc, hit;
  logic [1:0]    sel;
  logic          cpu_wr_data, cpu_pop;

  // control/status registers
  logic [DW-1:0] div_q, div_d;
  logic          ovf_q, ovf_d, ferr_q, ferr_d, orun_q, orun_d;
  logic [2:0]    clr;
  logic [7:0]    status;

  // FIFOs
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_push, tx_pop, rx_push, rx_push_req, rx_ferr_set;

  // transmitter
  uart_state_e   tx_state_q, tx_state_d;
  logic [DW-1:0] tx_tmr_q, tx_tmr_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          uart_tx_q, uart_tx_d;

  // receiver
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  uart_state_e   rx_state_q, rx_state_d;
  logic [DW-1:0] rx_tmr_q, rx_tmr_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [DW-1:0] rx_start_ld;

  assign wr_acc      = write_strobe & ~wr_q;
  assign rd_acc      = read_strobe & ~rd_q;
  assign hit         = (port_id[7:2] == BASE_PORT[7:2]);
  assign sel         = port_id[1:0];
  assign cpu_wr_data = hit & wr_acc & (sel == 2'd0);
  assign cpu_pop     = hit & rd_acc & (sel == 2'd0) & ~rx_empty;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);

  // a push into a full FIFO is still taken when a pop frees a slot in the same cycle
  assign tx_push = cpu_wr_data & (~tx_full | tx_pop);
  assign rx_push = rx_push_req & (~rx_full | cpu_pop);

  // half a bit period, rounded down, measured from the detected falling edge
  assign rx_start_ld = (div_q == '0) ? '0 : DW'((div_q - 16'd1) >> 1);

  assign status  = {ovf_q, ferr_q, orun_q, (tx_state_q != ST_IDLE),
                    tx_full, tx_empty, rx_full, ~rx_empty};
  assign uart_tx = uart_tx_q;

  // read mux: zero outside the window so responders can be OR-combined
  always_comb begin
    in_port = 8'h00;
    if (hit) begin
      case (sel)
        2'd0:    in_port = rx_empty ? 8'h00 : rx_mem[rx_rp_q];
        2'd1:    in_port = status;
        2'd2:    in_port = div_q[7:0];
        default: in_port = div_q[15:8];
      endcase
    end
  end

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    tx_wp_d  = tx_wp_q + AW'(tx_push);
    tx_rp_d  = tx_rp_q + AW'(tx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_wp_d  = rx_wp_q + AW'(rx_push);
    rx_rp_d  = rx_rp_q + AW'(cpu_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(cpu_pop);
  end

  // register writes and sticky flags (a set beats a clear in the same cycle)
  always_comb begin
    div_d = div_q;
    clr   = 3'b000;
    if (hit && wr_acc) begin
      case (sel)
        2'd1:    clr = out_port[7:5];
        2'd2:    div_d[7:0] = out_port;
        2'd3:    div_d[15:8] = out_port;
        default: ;
      endcase
    end
    ovf_d  = (ovf_q & ~clr[2]) | (cpu_wr_data & tx_full & ~tx_pop);
    ferr_d = (ferr_q & ~clr[1]) | rx_ferr_set;
    orun_d = (orun_q & ~clr[0]) | (rx_push_req & rx_full & ~cpu_pop);
  end

  // transmitter next state; the line register follows the state one cycle later
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tmr_q;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    uart_tx_d  = 1'b1;
    case (tx_state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_mem[tx_rp_q];
          tx_tmr_d   = div_q;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        uart_tx_d = 1'b0;
        if (tx_tmr_q == '0) begin
          tx_tmr_d   = div_q;
          tx_idx_d   = 3'd0;
          tx_state_d = ST_DATA;
        end else begin
          tx_tmr_d = tx_tmr_q - 16'd1;
        end
      end
      ST_DATA: begin
        uart_tx_d = tx_sh_q[0];
        if (tx_tmr_q == '0) begin
          tx_tmr_d = div_q;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_idx_d = tx_idx_q + 3'd1;
          if (tx_idx_q == 3'd7) tx_state_d = ST_STOP;
        end else begin
          tx_tmr_d = tx_tmr_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (tx_tmr_q == '0) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_mem[tx_rp_q];
            tx_tmr_d   = div_q;
            tx_state_d = ST_START;
          end else begin
            tx_state_d = ST_IDLE;
          end
        end else begin
          tx_tmr_d = tx_tmr_q - 16'd1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // receiver next state: mid-bit sampling of the synchronized line
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tmr_d    = rx_tmr_q;
    rx_idx_d    = rx_idx_q;
    rx_sh_d     = rx_sh_q;
    rx_push_req = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_tmr_d   = rx_start_ld;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_tmr_q == '0) begin
          if (rx_s2_q) begin
            rx_state_d = ST_IDLE;
          end else begin
            rx_tmr_d   = div_q;
            rx_idx_d   = 3'd0;
            rx_state_d = ST_DATA;
          end
        end else begin
          rx_tmr_d = rx_tmr_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (rx_tmr_q == '0) begin
          rx_tmr_d = div_q;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_idx_d = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_state_d = ST_STOP;
        end else begin
          rx_tmr_d = rx_tmr_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (rx_tmr_q == '0) begin
          rx_state_d  = ST_IDLE;
          rx_push_req = rx_s2_q;
          rx_ferr_set = ~rx_s2_q;
        end else begin
          rx_tmr_d = rx_tmr_q - 16'd1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      div_q      <= DEFAULT_DIV;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
      orun_q     <= 1'b0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
      tx_state_q <= ST_IDLE;
      tx_tmr_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      uart_tx_q  <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_tmr_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      wr_q       <= write_strobe;
      rd_q       <= read_strobe;
      div_q      <= div_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
      orun_q     <= orun_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      uart_tx_q  <= uart_tx_d;
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  // FIFO storage writes
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= out_port;
    if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;
  end

endmodule
